// File: rtl/cursor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cursor_pkg
// Purpose  : Shared types and default geometry for the cursor/pen controller.
//            FSM state encoding, default 160x120 screen geometry with its
//            centre point, and the colour used by the screen-clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
package cursor_pkg;

    // Controller states: normal pen drawing, or hardware framebuffer sweep
    typedef enum logic [0:0] {
        ST_DRAW  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Default screen geometry (160x120 framebuffer)
    localparam int DEF_X_W    = 8;
    localparam int DEF_Y_W    = 7;
    localparam int DEF_X_MAX  = 159;
    localparam int DEF_Y_MAX  = 119;
    localparam int DEF_X_INIT = 80;
    localparam int DEF_Y_INIT = 60;

    // Colour written by the clear sweep
    localparam int COL_BLACK  = 0;

endpackage
`default_nettype wire

// File: rtl/axis_stepper.sv
`default_nettype none
// ============================================================================
// Module   : axis_stepper
// Purpose  : Next-coordinate computation for one cursor axis. Applies a
//            signed step of 1 or 2 towards inc/dec, then clamps to [0, MAX]
//            or wraps modulo MAX+1 depending on WRAP. Pure combinational.
// Ports    : i_pos      current coordinate
//            i_inc      request to increase the coordinate
//            i_dec      request to decrease the coordinate
//            i_step     1 = step of 2, 0 = step of 1
//            o_next_pos coordinate after the step
//            o_moved    o_next_pos differs from i_pos
// Revision : 1.0 - initial release
// ============================================================================
module axis_stepper #(
    parameter int W    = 8,
    parameter int MAX  = 159,
    parameter bit WRAP = 1'b0
) (
    input  logic [W-1:0] i_pos,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_step,
    output logic [W-1:0] o_next_pos,
    output logic         o_moved
);

    // Two extra bits: one for sign, one so that MAX+2 never overflows even
    // when MAX sits right at the top of the W-bit range.
    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] c_MAX  = SW'(MAX);
    localparam logic signed [SW-1:0] c_SPAN = SW'(MAX + 1);

    logic signed [SW-1:0] w_mag;
    logic signed [SW-1:0] w_delta;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_res;

    // Opposing requests cancel to a zero delta
    always_comb begin
        w_mag   = i_step ? SW'(2) : SW'(1);
        w_delta = '0;
        if (i_inc && !i_dec) begin
            w_delta = w_mag;
        end else if (i_dec && !i_inc) begin
            w_delta = -w_mag;
        end
    end

    assign w_sum = $signed({2'b00, i_pos}) + w_delta;

    // A step is at most 2 and MAX >= 1, so one correction is always enough
    if (WRAP) begin : g_wrap
        always_comb begin
            w_res = w_sum;
            if (w_sum[SW-1]) begin
                w_res = w_sum + c_SPAN;
            end else if (w_sum > c_MAX) begin
                w_res = w_sum - c_SPAN;
            end
        end
    end else begin : g_clamp
        always_comb begin
            w_res = w_sum;
            if (w_sum[SW-1]) begin
                w_res = '0;
            end else if (w_sum > c_MAX) begin
                w_res = c_MAX;
            end
        end
    end

    assign o_next_pos = w_res[W-1:0];
    assign o_moved    = (o_next_pos != i_pos);

endmodule
`default_nettype wire

// File: rtl/cursor_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cursor_draw_ctrl
// Purpose  : Cursor/pen controller for the pixel-buffer VGA adapter. Moves a
//            drawing cursor from active-low direction buttons once per
//            divided tick, counts successful moves, and runs a row-major
//            screen-clear sweep on request before re-centring the cursor.
// Ports    : clock, reset              clock / synchronous active-high reset
//            btn_{left,right,up,down}_n active-low direction buttons
//            dot                       step of 2 instead of 1
//            pen_colour                colour plotted at the cursor
//            clear_req                 start a screen clear (level sampled)
//            x, y, colour, plot        registered adapter write port
//            busy                      high during the clear sweep
//            num_moves                 count of ticks that moved the cursor
// Revision : 1.0 - initial release
// ============================================================================
module cursor_draw_ctrl
    import cursor_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int Y_MAX    = DEF_Y_MAX,
    parameter int X_INIT   = DEF_X_INIT,
    parameter int Y_INIT   = DEF_Y_INIT,
    parameter int TICK_DIV = 524288,
    parameter bit WRAP     = 1'b0,
    parameter int CNT_W    = 16,
    parameter int COL_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_left_n,
    input  logic             btn_right_n,
    input  logic             btn_up_n,
    input  logic             btn_down_n,
    input  logic             dot,
    input  logic [COL_W-1:0] pen_colour,
    input  logic             clear_req,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic [CNT_W-1:0] num_moves
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0]    c_TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [X_W-1:0]   c_X_LAST    = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   c_Y_LAST    = Y_W'(Y_MAX);
    localparam logic [X_W-1:0]   c_X_INIT    = X_W'(X_INIT);
    localparam logic [Y_W-1:0]   c_Y_INIT    = Y_W'(Y_INIT);
    localparam logic [COL_W-1:0] c_BLACK     = COL_W'(COL_BLACK);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_tick_cnt;
    logic             w_tick;

    // r_x/r_y hold the cursor in DRAW and the sweep position in CLEAR; the
    // cursor does not need to survive a clear because it is re-centred after.
    logic [X_W-1:0]   r_x,      w_x_nxt;
    logic [Y_W-1:0]   r_y,      w_y_nxt;
    logic [COL_W-1:0] r_colour, w_colour_nxt;
    logic             r_plot,   w_plot_nxt;
    logic             r_busy,   w_busy_nxt;
    logic [CNT_W-1:0] r_moves,  w_moves_nxt;

    logic [X_W-1:0]   w_x_step;
    logic [Y_W-1:0]   w_y_step;
    logic             w_x_moved;
    logic             w_y_moved;

    // Free-running movement tick divider, active in every state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    axis_stepper #(
        .W    (X_W),
        .MAX  (X_MAX),
        .WRAP (WRAP)
    ) u_x_stepper (
        .i_pos      (r_x),
        .i_inc      (~btn_right_n),
        .i_dec      (~btn_left_n),
        .i_step     (dot),
        .o_next_pos (w_x_step),
        .o_moved    (w_x_moved)
    );

    // Screen y grows downwards
    axis_stepper #(
        .W    (Y_W),
        .MAX  (Y_MAX),
        .WRAP (WRAP)
    ) u_y_stepper (
        .i_pos      (r_y),
        .i_inc      (~btn_down_n),
        .i_dec      (~btn_up_n),
        .i_step     (dot),
        .o_next_pos (w_y_step),
        .o_moved    (w_y_moved)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_DRAW;
            r_x      <= c_X_INIT;
            r_y      <= c_Y_INIT;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_moves  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_busy   <= w_busy_nxt;
            r_moves  <= w_moves_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
        w_plot_nxt   = r_plot;
        w_busy_nxt   = r_busy;
        w_moves_nxt  = r_moves;

        case (r_state)
            ST_DRAW: begin
                w_plot_nxt = 1'b1;
                // A clear request wins over a coincident movement tick; the
                // first sweep pixel (0,0) is presented on entry to CLEAR.
                if (clear_req) begin
                    w_state_nxt  = ST_CLEAR;
                    w_x_nxt      = '0;
                    w_y_nxt      = '0;
                    w_colour_nxt = c_BLACK;
                    w_busy_nxt   = 1'b1;
                end else begin
                    w_colour_nxt = pen_colour;
                    if (w_tick) begin
                        w_x_nxt = w_x_step;
                        w_y_nxt = w_y_step;
                        // Diagonal moves count once; fully clamped moves not at all
                        if (w_x_moved || w_y_moved) begin
                            w_moves_nxt = r_moves + CNT_W'(1);
                        end
                    end
                end
            end

            ST_CLEAR: begin
                w_plot_nxt   = 1'b1;
                w_colour_nxt = c_BLACK;
                if (r_x == c_X_LAST) begin
                    if (r_y == c_Y_LAST) begin
                        // Last pixel is on the outputs now; return to drawing
                        w_state_nxt  = ST_DRAW;
                        w_x_nxt      = c_X_INIT;
                        w_y_nxt      = c_Y_INIT;
                        w_colour_nxt = pen_colour;
                        w_busy_nxt   = 1'b0;
                        w_moves_nxt  = '0;
                    end else begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + Y_W'(1);
                    end
                end else begin
                    w_x_nxt = r_x + X_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_DRAW;
            end
        endcase
    end

    assign x         = r_x;
    assign y         = r_y;
    assign colour    = r_colour;
    assign plot      = r_plot;
    assign busy      = r_busy;
    assign num_moves = r_moves;

endmodule
`default_nettype wire

// File: tb/tb_cursor_draw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_draw_ctrl
// Purpose  : Directed self-checking bench for cursor_draw_ctrl. Two
//            instances share stimulus: one saturating (16-bit counter), one
//            wrapping (4-bit counter, so counter wrap is exercised too).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_draw_ctrl;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_left_n = 1'b1, btn_right_n = 1'b1, btn_up_n = 1'b1, btn_down_n = 1'b1;
    logic       dot = 1'b0;
    logic [2:0] pen_colour = 3'd0;
    logic       clear_req = 1'b0;

    logic [7:0]  x,  xw;
    logic [6:0]  y,  yw;
    logic [2:0]  colour, colour_w;
    logic        plot, plot_w, busy, busy_w;
    logic [15:0] num_moves;
    logic [3:0]  moves_w;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    always #5 clock = ~clock;

    // Bench-side view of the tick phase: a tick edge is every TD-th edge after reset
    always @(posedge clock) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    cursor_draw_ctrl #(.TICK_DIV(TD), .WRAP(1'b0), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .dot(dot), .pen_colour(pen_colour), .clear_req(clear_req),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
        .num_moves(num_moves)
    );

    cursor_draw_ctrl #(.TICK_DIV(TD), .WRAP(1'b1), .CNT_W(4)) dut_w (
        .clock(clock), .reset(reset),
        .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .dot(dot), .pen_colour(pen_colour), .clear_req(clear_req),
        .x(xw), .y(yw), .colour(colour_w), .plot(plot_w), .busy(busy_w),
        .num_moves(moves_w)
    );

    // Buttons given as "pressed" flags; driven active-low
    task automatic set_btn(input logic l, input logic r, input logic u, input logic d, input logic dt);
        btn_left_n = ~l; btn_right_n = ~r; btn_up_n = ~u; btn_down_n = ~d; dot = dt;
    endtask

    // Hold current buttons for n tick edges, release, and land on a negedge
    task automatic wait_ticks(input int n);
        int got = 0;
        while (got < n) begin
            @(posedge clock); #1;
            if (edge_cnt % TD == 0) got++;
        end
        @(negedge clock);
        set_btn(0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        @(negedge clock); reset = 1'b1;
        @(posedge clock);
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock); reset = 1'b1; pen_colour = 3'd5;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors++; if (x !== 8'd80) begin miscompares++; $display("FAIL reset_x: got %0d expected 80", x); end
        vectors++; if (y !== 7'd60) begin miscompares++; $display("FAIL reset_y: got %0d expected 60", y); end
        vectors++; if (plot !== 1'b0) begin miscompares++; $display("FAIL reset_plot: got %0b expected 0", plot); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        vectors++; if (num_moves !== 16'd0) begin miscompares++; $display("FAIL reset_moves: got %0d expected 0", num_moves); end
        vectors++; if (colour !== 3'd0) begin miscompares++; $display("FAIL reset_colour: got %0d expected 0", colour); end
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (plot !== 1'b1) begin miscompares++; $display("FAIL draw_plot: got %0b expected 1", plot); end
        vectors++; if (colour !== 3'd5) begin miscompares++; $display("FAIL draw_colour: got %0d expected 5", colour); end
        pen_colour = 3'd2;
        @(negedge clock);
        vectors++; if (colour !== 3'd2) begin miscompares++; $display("FAIL draw_colour_follow: got %0d expected 2", colour); end
        pen_colour = 3'd5;
    endtask

    task automatic test_step_dot();
        set_btn(0, 1, 0, 0, 1);
        wait_ticks(1);
        vectors++; if (x !== 8'd82) begin miscompares++; $display("FAIL dot_right_x: got %0d expected 82", x); end
        vectors++; if (num_moves !== 16'd1) begin miscompares++; $display("FAIL dot_right_moves: got %0d expected 1", num_moves); end
        vectors++; if (xw !== 8'd82) begin miscompares++; $display("FAIL dot_right_xw: got %0d expected 82", xw); end
        set_btn(1, 1, 0, 0, 1);
        wait_ticks(1);
        vectors++; if (x !== 8'd82) begin miscompares++; $display("FAIL cancel_x: got %0d expected 82", x); end
        vectors++; if (num_moves !== 16'd1) begin miscompares++; $display("FAIL cancel_moves: got %0d expected 1", num_moves); end
    endtask

    task automatic test_diagonal();
        set_btn(0, 1, 1, 0, 0);
        wait_ticks(1);
        vectors++; if (x !== 8'd83) begin miscompares++; $display("FAIL diag_x: got %0d expected 83", x); end
        vectors++; if (y !== 7'd59) begin miscompares++; $display("FAIL diag_y: got %0d expected 59", y); end
        vectors++; if (num_moves !== 16'd2) begin miscompares++; $display("FAIL diag_moves: got %0d expected 2", num_moves); end
    endtask

    task automatic test_clamp();
        // 83 - 2*41 = 1, the 42nd dot step clamps at 0 but still moves
        set_btn(1, 0, 0, 0, 1);
        wait_ticks(42);
        vectors++; if (x !== 8'd0) begin miscompares++; $display("FAIL clamp_walk_x: got %0d expected 0", x); end
        vectors++; if (num_moves !== 16'd44) begin miscompares++; $display("FAIL clamp_walk_moves: got %0d expected 44", num_moves); end
        set_btn(1, 0, 0, 0, 0);
        wait_ticks(3);
        vectors++; if (x !== 8'd0) begin miscompares++; $display("FAIL clamp_left_x: got %0d expected 0", x); end
        vectors++; if (num_moves !== 16'd44) begin miscompares++; $display("FAIL clamp_left_moves: got %0d expected 44", num_moves); end
        set_btn(0, 0, 0, 1, 1);
        wait_ticks(30);
        vectors++; if (y !== 7'd119) begin miscompares++; $display("FAIL clamp_down_walk_y: got %0d expected 119", y); end
        vectors++; if (num_moves !== 16'd74) begin miscompares++; $display("FAIL clamp_down_walk_moves: got %0d expected 74", num_moves); end
        set_btn(0, 0, 0, 1, 0);
        wait_ticks(3);
        vectors++; if (y !== 7'd119) begin miscompares++; $display("FAIL clamp_down_y: got %0d expected 119", y); end
        vectors++; if (num_moves !== 16'd74) begin miscompares++; $display("FAIL clamp_down_moves: got %0d expected 74", num_moves); end
        vectors++; if (x !== 8'd0) begin miscompares++; $display("FAIL clamp_down_x: got %0d expected 0", x); end
    endtask

    task automatic test_wrap();
        apply_reset();
        set_btn(0, 1, 0, 0, 1);
        wait_ticks(39);
        vectors++; if (xw !== 8'd158) begin miscompares++; $display("FAIL wrap_walk_xw: got %0d expected 158", xw); end
        set_btn(0, 1, 0, 0, 0);
        wait_ticks(1);
        vectors++; if (xw !== 8'd159) begin miscompares++; $display("FAIL wrap_edge_xw: got %0d expected 159", xw); end
        vectors++; if (moves_w !== 4'd8) begin miscompares++; $display("FAIL wrap_edge_moves: got %0d expected 8", moves_w); end
        set_btn(0, 1, 0, 0, 0);
        wait_ticks(1);
        vectors++; if (xw !== 8'd0) begin miscompares++; $display("FAIL wrap_right_xw: got %0d expected 0", xw); end
        vectors++; if (moves_w !== 4'd9) begin miscompares++; $display("FAIL wrap_right_moves: got %0d expected 9", moves_w); end
        vectors++; if (x !== 8'd159) begin miscompares++; $display("FAIL sat_right_x: got %0d expected 159", x); end
        vectors++; if (num_moves !== 16'd40) begin miscompares++; $display("FAIL sat_right_moves: got %0d expected 40", num_moves); end
        set_btn(1, 0, 0, 0, 1);
        wait_ticks(1);
        vectors++; if (xw !== 8'd158) begin miscompares++; $display("FAIL wrap_left_dot_xw: got %0d expected 158", xw); end
        vectors++; if (moves_w !== 4'd10) begin miscompares++; $display("FAIL wrap_left_dot_moves: got %0d expected 10", moves_w); end
        vectors++; if (x !== 8'd157) begin miscompares++; $display("FAIL sat_left_dot_x: got %0d expected 157", x); end
    endtask

    task automatic test_clear();
        int errs = 0;
        logic [7:0] ex;
        logic [6:0] ey;
        @(negedge clock);
        clear_req = 1'b1;
        set_btn(0, 1, 0, 1, 1);             // must be ignored by the sweep
        @(negedge clock);
        clear_req = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            ex = 8'(i % 160);
            ey = 7'(i / 160);
            if (x !== ex || y !== ey || colour !== 3'd0 || plot !== 1'b1 || busy !== 1'b1 ||
                xw !== ex || yw !== ey || busy_w !== 1'b1)
                errs++;
            if (i == 0) begin
                vectors++; if (x !== 8'd0 || y !== 7'd0) begin miscompares++; $display("FAIL clear_first: got (%0d,%0d) expected (0,0)", x, y); end
            end
            if (i == 160) begin
                vectors++; if (x !== 8'd0 || y !== 7'd1) begin miscompares++; $display("FAIL clear_pix161: got (%0d,%0d) expected (0,1)", x, y); end
            end
            if (i == 19199) begin
                vectors++; if (x !== 8'd159 || y !== 7'd119) begin miscompares++; $display("FAIL clear_last: got (%0d,%0d) expected (159,119)", x, y); end
                set_btn(0, 0, 0, 0, 0);
            end
            @(negedge clock);
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL clear_sweep: got %0d bad cycles expected 0", errs); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_done_busy: got %0b expected 0", busy); end
        vectors++; if (x !== 8'd80 || y !== 7'd60) begin miscompares++; $display("FAIL clear_done_pos: got (%0d,%0d) expected (80,60)", x, y); end
        vectors++; if (num_moves !== 16'd0) begin miscompares++; $display("FAIL clear_done_moves: got %0d expected 0", num_moves); end
        vectors++; if (plot !== 1'b1 || colour !== 3'd5) begin miscompares++; $display("FAIL clear_done_draw: got plot=%0b colour=%0d expected plot=1 colour=5", plot, colour); end
        vectors++; if (xw !== 8'd80 || moves_w !== 4'd0 || busy_w !== 1'b0) begin miscompares++; $display("FAIL clear_done_w: got x=%0d moves=%0d busy=%0b expected 80 0 0", xw, moves_w, busy_w); end
    endtask

    task automatic test_retrigger_and_abort();
        int errs = 0;
        @(negedge clock);
        clear_req = 1'b1;                   // held through the whole sweep
        @(negedge clock);
        for (int i = 0; i < 19200; i++) begin
            if (busy !== 1'b1) errs++;
            @(negedge clock);
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL retrig_busy: got %0d idle cycles expected 0", errs); end
        vectors++; if (busy !== 1'b0 || x !== 8'd80 || y !== 7'd60) begin miscompares++; $display("FAIL retrig_draw_cycle: got busy=%0b (%0d,%0d) expected busy=0 (80,60)", busy, x, y); end
        @(negedge clock);
        vectors++; if (busy !== 1'b1 || x !== 8'd0 || y !== 7'd0) begin miscompares++; $display("FAIL retrig_restart: got busy=%0b (%0d,%0d) expected busy=1 (0,0)", busy, x, y); end
        repeat (500) @(negedge clock);
        vectors++; if (x !== 8'd20 || y !== 7'd3) begin miscompares++; $display("FAIL abort_pix500: got (%0d,%0d) expected (20,3)", x, y); end
        reset = 1'b1;
        clear_req = 1'b0;
        @(negedge clock);
        vectors++; if (busy !== 1'b0 || plot !== 1'b0) begin miscompares++; $display("FAIL abort_flags: got busy=%0b plot=%0b expected 0 0", busy, plot); end
        vectors++; if (x !== 8'd80 || y !== 7'd60) begin miscompares++; $display("FAIL abort_pos: got (%0d,%0d) expected (80,60)", x, y); end
        vectors++; if (colour !== 3'd0 || num_moves !== 16'd0) begin miscompares++; $display("FAIL abort_regs: got colour=%0d moves=%0d expected 0 0", colour, num_moves); end
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if ((plot === 1'b1 && colour === 3'd0) || busy !== 1'b0) errs++;
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL abort_no_black: got %0d black writes expected 0", errs); end
    endtask

    initial begin
        test_reset();
        test_step_dot();
        test_diagonal();
        test_clamp();
        test_wrap();
        test_clear();
        test_retrigger_and_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
